store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_store_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
//==============================================================================
// Module   : store_unit (with companion package store_unit_pkg)
// Purpose  : Executes SB/SH/SW store micro-ops. It computes the effective
//            address, checks alignment, places the data in its byte lanes and
//            issues one dword-wide write to memory. Completion is reported as a
//            one-cycle done pulse. A misaligned address or a missing
//            acknowledge is reported as a one-cycle exception pulse.
// Ports    : clk, rst_n                     clock, synchronous active-low reset
//            in_valid/in_ready              upstream micro-op handshake
//            in_op, in_base, in_imm, in_data  operation and operands
//            mem_req/addr/wdata/wstrb       write request, held until mem_ack
//            mem_ack                        memory accepted the write
//            done                           retired without exception
//            exc_valid/exc_cause/exc_addr   exception report
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

package store_unit_pkg;
    typedef logic [2:0] oper_t;

    localparam oper_t OP_NOP = 3'd0;
    localparam oper_t OP_SB  = 3'd1;
    localparam oper_t OP_SH  = 3'd2;
    localparam oper_t OP_SW  = 3'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
endpackage

module store_unit
    import store_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  oper_t       in_op,
    input  logic [63:0] in_base,
    input  logic [63:0] in_imm,
    input  logic [63:0] in_data,

    output logic        mem_req,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,

    output logic        done,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [63:0] exc_addr
);

    // The wait counter only has to represent 0 .. ACK_TIMEOUT-1: the cycle in
    // which it would step onto ACK_TIMEOUT is the cycle that raises the
    // timeout, so that value never needs to be stored.
    localparam int unsigned c_cnt_w = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIN  = 2'd2,
        S_EXC  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [1:0]           r_cause;
    logic [1:0]           w_cause_nxt;
    logic [63:0]          r_ea;
    logic [63:0]          r_wdata;
    logic [7:0]           r_wstrb;

    //--------------------------------------------------------------------------
    // Decode of the offered micro-op
    //--------------------------------------------------------------------------
    logic        w_accept;
    logic [63:0] w_ea;
    logic        w_is_sb;
    logic        w_is_sh;
    logic        w_is_sw;
    logic        w_is_store;
    logic        w_misaligned;
    logic [7:0]  w_lane_strb;
    logic [63:0] w_lane_data;
    logic [7:0]  w_wstrb;
    logic [63:0] w_wdata;

    // in_ready already contains rst_n, so nothing is accepted during reset.
    assign w_accept     = in_valid && in_ready;

    // 64-bit add: the carry-out is dropped, giving wrap-around addressing.
    assign w_ea         = in_base + in_imm;

    assign w_is_sb      = (in_op == OP_SB);
    assign w_is_sh      = (in_op == OP_SH);
    assign w_is_sw      = (in_op == OP_SW);
    assign w_is_store   = w_is_sb || w_is_sh || w_is_sw;
    assign w_misaligned = (w_is_sh && w_ea[0]) || (w_is_sw && (w_ea[1:0] != 2'b00));

    // Byte enables and data are first formed at lane 0, then moved to the
    // byte offset within the dword. An aligned access never crosses the
    // dword, so nothing is lost off the top of the shift.
    always_comb begin
        w_lane_strb = 8'h00;
        w_lane_data = 64'd0;
        if (w_is_sb) begin
            w_lane_strb = 8'h01;
            w_lane_data = {56'd0, in_data[7:0]};
        end else if (w_is_sh) begin
            w_lane_strb = 8'h03;
            w_lane_data = {48'd0, in_data[15:0]};
        end else if (w_is_sw) begin
            w_lane_strb = 8'h0F;
            w_lane_data = {32'd0, in_data[31:0]};
        end
    end

    assign w_wstrb = w_lane_strb << w_ea[2:0];
    assign w_wdata = w_lane_data << {w_ea[2:0], 3'b000};

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (!w_is_store) begin
                        w_state_nxt = S_FIN;
                    end else if (w_misaligned) begin
                        w_state_nxt = S_EXC;
                        w_cause_nxt = CAUSE_MISALIGN;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                // Acknowledge is tested first so that an ack arriving in the
                // final allowed cycle still completes normally.
                if (mem_ack) begin
                    w_state_nxt = S_FIN;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_EXC;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end

            S_FIN: begin
                w_state_nxt = S_IDLE;
            end

            S_EXC: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and operand registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cause <= CAUSE_NONE;
            r_ea    <= 64'd0;
            r_wdata <= 64'd0;
            r_wstrb <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cause <= w_cause_nxt;
            if (w_accept) begin
                r_ea    <= w_ea;
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    // Every output is gated by rst_n so the unit is silent for as long as
    // reset is held, not only from the first reset edge onward.
    //--------------------------------------------------------------------------
    logic w_busy;
    logic w_fin;
    logic w_exc;

    assign w_busy    = rst_n && (r_state == S_BUSY);
    assign w_fin     = rst_n && (r_state == S_FIN);
    assign w_exc     = rst_n && (r_state == S_EXC);

    assign in_ready  = rst_n && (r_state == S_IDLE);

    assign mem_req   = w_busy;
    assign mem_addr  = w_busy ? {r_ea[63:3], 3'b000} : 64'd0;
    assign mem_wdata = w_busy ? r_wdata : 64'd0;
    assign mem_wstrb = w_busy ? r_wstrb : 8'h00;

    assign done      = w_fin;
    assign exc_valid = w_exc;
    assign exc_cause = w_exc ? r_cause : CAUSE_NONE;
    assign exc_addr  = w_exc ? r_ea : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_store_unit.sv
//==============================================================================
// Module   : tb_store_unit
// Purpose  : Self-checking bench for store_unit. Directed and random store
//            micro-ops are offered. A reference model derives each expected
//            response from the architectural rules and queues it. A monitor
//            compares every memory request and every done/exception pulse
//            against the queued expectations. A responder acknowledges writes
//            after a per-op delay, some of which deliberately exceed the
//            timeout.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_store_unit;
    import store_unit_pkg::*;

    localparam int ACK_TIMEOUT = 16;
    localparam int N_RANDOM    = 250;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    oper_t       in_op;
    logic [63:0] in_base;
    logic [63:0] in_imm;
    logic [63:0] in_data;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic        done;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [63:0] exc_addr;

    always #5 clk = ~clk;

    store_unit #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .in_data   (in_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .done      (done),
        .exc_valid (exc_valid),
        .exc_cause (exc_cause),
        .exc_addr  (exc_addr)
    );

    typedef struct {
        bit          is_exc;
        logic [1:0]  cause;
        logic [63:0] ea;
        bit          has_mem;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          req_cycles;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   ack_q[$];

    int   n_checks  = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   exp_gap   = 0;
    bit   mon_en    = 1'b0;
    bit   force_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual=0x%h expected=0x%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: works from byte counts and byte offsets.
    function automatic exp_t model(input oper_t op, input logic [63:0] base,
                                   input logic [63:0] imm, input logic [63:0] data,
                                   input int d);
        exp_t e;
        int   nb;
        int   off;
        e.ea         = base + imm;
        e.is_exc     = 1'b0;
        e.cause      = 2'b00;
        e.has_mem    = 1'b0;
        e.addr       = 64'd0;
        e.wdata      = 64'd0;
        e.strb       = 8'h00;
        e.req_cycles = 0;
        e.acc_cyc    = 0;
        nb = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : (op == OP_SW) ? 4 : 0;
        if (nb == 0) begin
            // not a store: completes without touching memory
        end else if ((e.ea % 64'(nb)) != 64'd0) begin
            e.is_exc = 1'b1;
            e.cause  = 2'b01;
        end else begin
            e.has_mem = 1'b1;
            e.addr    = e.ea & ~64'h7;
            off       = int'(e.ea % 64'd8);
            for (int b = 0; b < nb; b++) begin
                e.strb[off + b]            = 1'b1;
                e.wdata[8*(off + b) +: 8]  = data[8*b +: 8];
            end
            if (d <= ACK_TIMEOUT) begin
                e.req_cycles = d;
            end else begin
                e.is_exc     = 1'b1;
                e.cause      = 2'b10;
                e.req_cycles = ACK_TIMEOUT;
            end
        end
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    // d is the BUSY cycle (1-based) in which the responder acknowledges.
    task automatic issue(input oper_t op, input logic [63:0] base, input logic [63:0] imm,
                         input logic [63:0] data, input int d, input bit push);
        exp_t e;
        int   waitc;
        e = model(op, base, imm, data, d);
        if (e.has_mem) ack_q.push_back(d);
        in_valid = 1'b1;
        in_op    = op;
        in_base  = base;
        in_imm   = imm;
        in_data  = data;
        waitc    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitc++;
            if (waitc > 100) break;
        end
        if (!in_ready) begin
            check(1'b0, "accept_timeout", 64'(waitc), 64'd0);
            in_valid = 1'b0;
            return;
        end
        if (exp_gap >= 0) check(waitc == exp_gap, "accept_gap", 64'(waitc), 64'(exp_gap));
        e.acc_cyc = cyc + 1;
        exp_gap   = e.req_cycles + 1;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_base  = {$urandom, $urandom};
    endtask

    //--------------------------------------------------------------------------
    // Memory responder
    //--------------------------------------------------------------------------
    initial begin
        bit active = 1'b0;
        int n      = 0;
        int dcur   = 0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                mem_ack = 1'b1;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    n      = 1;
                    dcur   = (ack_q.size() > 0) ? ack_q.pop_front() : 1000;
                end else begin
                    n++;
                end
                mem_ack = (n == dcur);
            end else begin
                active  = 1'b0;
                // stray acks while not busy must be ignored by the unit
                mem_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Monitor / scoreboard
    //--------------------------------------------------------------------------
    exp_t        mon_cur;
    bit          mon_have = 1'b0;
    int          req_cnt  = 0;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_strb;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                mon_have = 1'b0;
                req_cnt  = 0;
                continue;
            end
            if (mem_req) begin
                if (req_cnt == 0) begin
                    if (!mon_have) begin
                        if (sb_q.size() == 0) begin
                            check(1'b0, "unexpected_mem_req", mem_addr, 64'd0);
                        end else begin
                            mon_cur  = sb_q.pop_front();
                            mon_have = 1'b1;
                        end
                    end
                    if (mon_have) begin
                        check(mon_cur.has_mem, "mem_req_expected", 64'd1, 64'(mon_cur.has_mem));
                        check(mem_addr == mon_cur.addr, "mem_addr", mem_addr, mon_cur.addr);
                        check(mem_wdata == mon_cur.wdata, "mem_wdata", mem_wdata, mon_cur.wdata);
                        check(mem_wstrb == mon_cur.strb, "mem_wstrb", 64'(mem_wstrb), 64'(mon_cur.strb));
                    end
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    cap_strb  = mem_wstrb;
                end else begin
                    check(mem_addr == cap_addr && mem_wdata == cap_wdata && mem_wstrb == cap_strb,
                          "mem_stable", mem_wdata, cap_wdata);
                end
                req_cnt++;
            end else begin
                check(mem_addr == 64'd0 && mem_wdata == 64'd0 && mem_wstrb == 8'h00,
                      "mem_idle_zero", mem_addr | mem_wdata | 64'(mem_wstrb), 64'd0);
            end

            if (done || exc_valid) begin
                check(!(done && exc_valid), "done_exc_exclusive", {62'd0, done, exc_valid}, 64'd0);
                if (!mon_have) begin
                    if (sb_q.size() == 0) begin
                        check(1'b0, "unexpected_response", {62'd0, done, exc_valid}, 64'd0);
                    end else begin
                        mon_cur  = sb_q.pop_front();
                        mon_have = 1'b1;
                    end
                end
                if (mon_have) begin
                    check(exc_valid == mon_cur.is_exc, "outcome_is_exc", 64'(exc_valid), 64'(mon_cur.is_exc));
                    if (mon_cur.is_exc) begin
                        check(exc_cause == mon_cur.cause, "exc_cause", 64'(exc_cause), 64'(mon_cur.cause));
                        check(exc_addr == mon_cur.ea, "exc_addr", exc_addr, mon_cur.ea);
                    end
                    check(req_cnt == mon_cur.req_cycles, "mem_req_cycles", 64'(req_cnt), 64'(mon_cur.req_cycles));
                    check(cyc == mon_cur.acc_cyc + mon_cur.req_cycles, "resp_latency",
                          64'(cyc), 64'(mon_cur.acc_cyc + mon_cur.req_cycles));
                end
                mon_have = 1'b0;
                req_cnt  = 0;
            end else begin
                check(exc_cause == 2'b00 && exc_addr == 64'd0, "exc_fields_zero",
                      exc_addr | 64'(exc_cause), 64'd0);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Watchdog
    //--------------------------------------------------------------------------
    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, actual=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        oper_t       op;
        logic [63:0] base;
        logic [63:0] imm;
        logic [63:0] data;
        logic [63:0] mk;
        logic [11:0] r12;
        int          r;
        int          d;
        int          drain;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = OP_NOP;
        in_base  = 64'd0;
        in_imm   = 64'd0;
        in_data  = 64'd0;

        repeat (3) begin
            @(negedge clk);
            check(!in_ready && !mem_req && !done && !exc_valid, "reset_outputs",
                  {60'd0, in_ready, mem_req, done, exc_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        exp_gap = 0;

        // Directed cases
        issue(OP_SB, 64'h1000, 64'h5, 64'hAB, 3, 1'b1);
        issue(OP_SW, 64'h2002, 64'h0, 64'h12345678, 1, 1'b1);
        issue(OP_SW, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h12345678, 2, 1'b1);
        issue(OP_SH, 64'h3000, 64'h2, 64'hBEEF, ACK_TIMEOUT + 1, 1'b1);
        issue(OP_SH, 64'h3000, 64'h6, 64'hCAFE, ACK_TIMEOUT, 1'b1);
        issue(OP_NOP, 64'h5, 64'h6, 64'h7, 1, 1'b1);
        issue(oper_t'(3'd5), 64'h1001, 64'h0, 64'h7, 1, 1'b1);
        issue(OP_SH, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 1'b1);
        issue(OP_SB, 64'h4007, 64'h0, 64'hFFFF_FFFF_FFFF_FF5A, 1, 1'b1);

        // Random cases
        for (int i = 0; i < N_RANDOM; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      op = OP_SB;
            else if (r < 6) op = OP_SH;
            else if (r < 9) op = OP_SW;
            else if ($urandom_range(0, 4) == 0) op = OP_NOP;
            else            op = oper_t'($urandom_range(4, 7));
            base = {$urandom, $urandom};
            r12  = 12'($urandom);
            imm  = {{52{r12[11]}}, r12};
            if ($urandom_range(0, 7) == 0) imm = {$urandom, $urandom};
            mk   = (op == OP_SH) ? 64'd1 : (op == OP_SW) ? 64'd3 : 64'd0;
            if ($urandom_range(0, 2) != 0) base = base - ((base + imm) & mk);
            data = {$urandom, $urandom};
            d    = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 18) : $urandom_range(1, 8);
            issue(op, base, imm, data, d, 1'b1);
        end

        drain = 0;
        while ((sb_q.size() != 0 || mon_have) && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        check(sb_q.size() == 0 && !mon_have, "scoreboard_drained", 64'(sb_q.size()), 64'd0);

        // Reset in the middle of a BUSY store, with ack arriving afterwards
        @(posedge clk);
        #1;
        mon_en  = 1'b0;
        exp_gap = -1;
        issue(OP_SW, 64'h4000, 64'h0, 64'h12345678, 100, 1'b0);
        @(negedge clk);
        check(mem_req == 1'b1, "rst_test_busy", 64'(mem_req), 64'd1);
        rst_n     = 1'b0;
        force_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check(!in_ready && !mem_req && !done && !exc_valid, "reset_mid_busy",
                  {60'd0, in_ready, mem_req, done, exc_valid}, 64'd0);
        end
        ack_q.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_op    = OP_NOP;
        @(negedge clk);
        check(in_ready && !done && !exc_valid && !mem_req, "first_cycle_after_reset",
              {60'd0, in_ready, mem_req, done, exc_valid}, 64'h8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check(done && !exc_valid && !mem_req, "nop_done_after_reset",
              {61'd0, mem_req, done, exc_valid}, 64'h2);
        @(negedge clk);
        check(!done && !exc_valid && !mem_req, "no_extra_pulse",
              {61'd0, mem_req, done, exc_valid}, 64'd0);
        force_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
